// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_ctrl
// Description : Multi-cycle control unit for a small ARMv8-style subset
//               (ADDI, ADDS, SUBS, LDUR, STUR, B, CBZ, B.LT). Latches the
//               instruction in FETCH and sequences DECODE/EXEC/MEM/WB.
//               All datapath controls are combinational from state, ir and
//               the live status inputs. Unknown opcodes park the unit in ERR.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] instr_in,
  input  logic        zero,
  input  logic        flag_n,
  input  logic        flag_v,
  input  logic        mem_ready,
  output logic [31:0] ir,
  output logic [2:0]  state,
  output logic        ir_en,
  output logic        pc_en,
  output logic        br_taken,
  output logic        uncond_br,
  output logic        reg2loc,
  output logic        alu_src,
  output logic        imm_sel,
  output logic [2:0]  alu_op,
  output logic        flag_en,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        err
);

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERR    = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    OP_ILLEGAL = 4'd0,
    OP_ADDI    = 4'd1,
    OP_ADDS    = 4'd2,
    OP_SUBS    = 4'd3,
    OP_LDUR    = 4'd4,
    OP_STUR    = 4'd5,
    OP_B       = 4'd6,
    OP_CBZ     = 4'd7,
    OP_BLT     = 4'd8
  } op_t;

  state_t cur_state;
  state_t next_state;
  op_t    op;

  assign state = cur_state;

  // Classify the latched instruction; ir is stable from DECODE to retirement.
  always_comb begin
    op = OP_ILLEGAL;
    if (ir[31:22] == 10'b1001000100)
      op = OP_ADDI;
    else if (ir[31:21] == 11'b10101011000)
      op = OP_ADDS;
    else if (ir[31:21] == 11'b11101011000)
      op = OP_SUBS;
    else if (ir[31:21] == 11'b11111000010)
      op = OP_LDUR;
    else if (ir[31:21] == 11'b11111000000)
      op = OP_STUR;
    else if (ir[31:26] == 6'b000101)
      op = OP_B;
    else if (ir[31:24] == 8'b10110100)
      op = OP_CBZ;
    else if (ir[31:24] == 8'b01010100 && ir[4:0] == 5'b01011)
      op = OP_BLT;
  end

  // State register and instruction latch; reset clears both immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= FETCH;
      ir        <= '0;
    end else begin
      cur_state <= next_state;
      if (ir_en)
        ir <= instr_in;
    end
  end

  // Next-state and control outputs; every control defaults low.
  always_comb begin
    next_state = cur_state;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    br_taken   = 1'b0;
    uncond_br  = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    imm_sel    = 1'b0;
    alu_op     = ALU_PASS_B;
    flag_en    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    err        = 1'b0;

    case (cur_state)
      FETCH: begin
        // reset holds the unit in FETCH, so only the fetch enable needs gating
        if (run && !reset) begin
          ir_en      = 1'b1;
          next_state = DECODE;
        end
      end

      DECODE: begin
        next_state = (op == OP_ILLEGAL) ? ERR : EXEC;
      end

      EXEC: begin
        case (op)
          OP_ADDI: begin
            alu_src    = 1'b1;
            alu_op     = ALU_ADD;
            next_state = WB;
          end
          OP_ADDS: begin
            reg2loc    = 1'b1;
            alu_op     = ALU_ADD;
            flag_en    = 1'b1;
            next_state = WB;
          end
          OP_SUBS: begin
            reg2loc    = 1'b1;
            alu_op     = ALU_SUB;
            flag_en    = 1'b1;
            next_state = WB;
          end
          OP_LDUR, OP_STUR: begin
            alu_src    = 1'b1;
            imm_sel    = 1'b1;
            alu_op     = ALU_ADD;
            next_state = MEM;
          end
          OP_B: begin
            pc_en      = 1'b1;
            br_taken   = 1'b1;
            uncond_br  = 1'b1;
            next_state = FETCH;
          end
          OP_CBZ: begin
            pc_en      = 1'b1;
            br_taken   = zero;
            next_state = FETCH;
          end
          OP_BLT: begin
            pc_en      = 1'b1;
            br_taken   = flag_n ^ flag_v;
            next_state = FETCH;
          end
          default: next_state = ERR;
        endcase
      end

      MEM: begin
        // address operands stay valid for the whole access
        alu_src = 1'b1;
        imm_sel = 1'b1;
        alu_op  = ALU_ADD;
        if (op == OP_LDUR) begin
          mem_read = 1'b1;
          if (mem_ready)
            next_state = WB;
        end else begin
          mem_write = 1'b1;
          if (mem_ready) begin
            pc_en      = 1'b1;
            next_state = FETCH;
          end
        end
      end

      WB: begin
        reg_write  = 1'b1;
        pc_en      = 1'b1;
        next_state = FETCH;
        if (op == OP_LDUR) begin
          mem_to_reg = 1'b1;
          mem_read   = 1'b1;
        end
      end

      ERR: begin
        err = 1'b1;
      end

      default: next_state = ERR;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_ctrl
// Description : Self-checking bench for multi_cycle_ctrl. Directed vector
//               table, hand sequences for ERR and reset-in-MEM, and random
//               instructions checked against an instruction-level model
//               (latency, retire behaviour and per-instruction enable counts).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] instr_in;
  logic        zero, flag_n, flag_v, mem_ready;
  logic [31:0] ir;
  logic [2:0]  state;
  logic        ir_en, pc_en, br_taken, uncond_br;
  logic        reg2loc, alu_src, imm_sel;
  logic [2:0]  alu_op;
  logic        flag_en, mem_read, mem_write, mem_to_reg, reg_write, err;
  logic [14:0] ctrl;

  int checks = 0;
  int errors = 0;

  multi_cycle_ctrl dut (
    .clk(clk), .reset(reset), .run(run), .instr_in(instr_in),
    .zero(zero), .flag_n(flag_n), .flag_v(flag_v), .mem_ready(mem_ready),
    .ir(ir), .state(state), .ir_en(ir_en), .pc_en(pc_en),
    .br_taken(br_taken), .uncond_br(uncond_br), .reg2loc(reg2loc),
    .alu_src(alu_src), .imm_sel(imm_sel), .alu_op(alu_op),
    .flag_en(flag_en), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .err(err)
  );

  always #5 clk = ~clk;

  assign ctrl = {ir_en, pc_en, br_taken, uncond_br, reg2loc, alu_src, imm_sel,
                 alu_op, flag_en, mem_read, mem_write, mem_to_reg, reg_write};

  // Per-instruction expectations: latency, retire-cycle branch outputs,
  // number of cycles each enable is high, EXEC operand selects.
  typedef struct {
    int         lat;
    bit         br;
    bit         unc;
    int         rw;
    int         mr;
    int         mw;
    int         fe;
    int         mtr;
    logic [5:0] exec;   // {reg2loc, alu_src, imm_sel, alu_op}
    bit         mem;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    bit          z;
    bit          n;
    bit          v;
    int          w;
    exp_t        e;
  } vec_t;

  function automatic exp_t mk_exp(input int lat, input bit br, input bit unc,
                                  input int rw, input int mr, input int mw,
                                  input int fe, input int mtr,
                                  input logic [5:0] exec, input bit mem);
    exp_t e;
    e.lat = lat; e.br = br; e.unc = unc; e.rw = rw; e.mr = mr; e.mw = mw;
    e.fe = fe; e.mtr = mtr; e.exec = exec; e.mem = mem;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic [31:0] instr, input bit z,
                                  input bit n, input bit v, input int w,
                                  input exp_t e);
    vec_t t;
    t.instr = instr; t.z = z; t.n = n; t.v = v; t.w = w; t.e = e;
    return t;
  endfunction

  // Instruction classes: 0 ADDI 1 ADDS 2 SUBS 3 LDUR 4 STUR 5 B 6 CBZ 7 B.LT
  function automatic logic [31:0] mk_instr(input int c);
    logic [31:0] r;
    r = $urandom;
    case (c)
      0: r[31:22] = 10'b1001000100;
      1: r[31:21] = 11'b10101011000;
      2: r[31:21] = 11'b11101011000;
      3: r[31:21] = 11'b11111000010;
      4: r[31:21] = 11'b11111000000;
      5: r[31:26] = 6'b000101;
      6: r[31:24] = 8'b10110100;
      default: begin
        r[31:24] = 8'b01010100;
        r[4:0]   = 5'b01011;
      end
    endcase
    return r;
  endfunction

  // Instruction-level reference: what one retired instruction must look like.
  function automatic exp_t model(input int c, input bit z, input bit n,
                                 input bit v, input int w);
    case (c)
      0: return mk_exp(4, 0, 0, 1, 0, 0, 0, 0, 6'b010010, 0);
      1: return mk_exp(4, 0, 0, 1, 0, 0, 1, 0, 6'b100010, 0);
      2: return mk_exp(4, 0, 0, 1, 0, 0, 1, 0, 6'b100011, 0);
      3: return mk_exp(5 + w, 0, 0, 1, w + 2, 0, 0, 1, 6'b011010, 1);
      4: return mk_exp(4 + w, 0, 0, 0, 0, w + 1, 0, 0, 6'b011010, 1);
      5: return mk_exp(3, 1, 1, 0, 0, 0, 0, 0, 6'b000000, 0);
      6: return mk_exp(3, z, 0, 0, 0, 0, 0, 0, 6'b000000, 0);
      default: return mk_exp(3, n ^ v, 0, 0, 0, 0, 0, 0, 6'b000000, 0);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one instruction from its fetch cycle to its pc_en cycle and compare
  // the observed behaviour against the expectation record.
  task automatic run_instr(input string tag, input logic [31:0] instr,
                           input bit z, input bit n, input bit v, input int w,
                           input exp_t e);
    int lat, rw_c, mr_c, mw_c, fe_c, mtr_c, viol;
    logic br_at, unc_at;
    logic [5:0] exec_v;
    bit done;
    lat = 0; rw_c = 0; mr_c = 0; mw_c = 0; fe_c = 0; mtr_c = 0; viol = 0;
    br_at = 1'b0; unc_at = 1'b0; exec_v = '0; done = 1'b0;
    for (int cyc = 0; cyc < 24 && !done; cyc++) begin
      @(negedge clk);
      zero = z; flag_n = n; flag_v = v;
      if (cyc == 0) begin
        run = 1'b1; instr_in = instr;
      end else begin
        run = 1'($urandom); instr_in = $urandom;
      end
      if (e.mem && cyc >= 3 && cyc <= 3 + w)
        mem_ready = (cyc == 3 + w);
      else
        mem_ready = 1'($urandom);
      #1;
      if (cyc == 0 && (state !== 3'd0 || ir_en !== 1'b1)) viol++;
      if (cyc > 0 && (ir_en !== 1'b0 || ir !== instr)) viol++;
      if (mem_write && reg_write) viol++;
      if (flag_en && state !== 3'd2) viol++;
      if (err !== 1'b0) viol++;
      if (!pc_en && (br_taken || uncond_br)) viol++;
      if (cyc == 2) exec_v = {reg2loc, alu_src, imm_sel, alu_op};
      if (reg_write)  rw_c++;
      if (mem_read)   mr_c++;
      if (mem_write)  mw_c++;
      if (flag_en)    fe_c++;
      if (mem_to_reg) mtr_c++;
      if (pc_en) begin
        done   = 1'b1;
        lat    = cyc + 1;
        br_at  = br_taken;
        unc_at = uncond_br;
      end
    end
    chk($sformatf("%s latency", tag), lat, e.lat);
    chk($sformatf("%s br_taken", tag), br_at, e.br);
    chk($sformatf("%s uncond_br", tag), unc_at, e.unc);
    chk($sformatf("%s reg_write cycles", tag), rw_c, e.rw);
    chk($sformatf("%s mem_read cycles", tag), mr_c, e.mr);
    chk($sformatf("%s mem_write cycles", tag), mw_c, e.mw);
    chk($sformatf("%s flag_en cycles", tag), fe_c, e.fe);
    chk($sformatf("%s mem_to_reg cycles", tag), mtr_c, e.mtr);
    chk($sformatf("%s exec selects", tag), exec_v, e.exec);
    chk($sformatf("%s cycle violations", tag), viol, 0);
  endtask

  // Illegal opcode: DECODE then ERR, held regardless of run/mem_ready, until reset.
  task automatic err_seq(input string tag, input logic [31:0] instr, input int ncyc);
    int viol;
    viol = 0;
    @(negedge clk); run = 1'b1; instr_in = instr; mem_ready = 1'b0; #1;
    chk({tag, " fetch ir_en"}, ir_en, 1);
    @(negedge clk); run = 1'b0; instr_in = $urandom; #1;
    chk({tag, " decode state"}, state, 1);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk); run = i[0]; mem_ready = 1'($urandom); instr_in = $urandom; #1;
      if (state !== 3'd7 || err !== 1'b1 || ctrl !== 15'd0 || ir !== instr) viol++;
    end
    chk({tag, " err hold violations"}, viol, 0);
    #2 reset = 1'b1; #1;
    chk({tag, " reset err"}, err, 0);
    chk({tag, " reset state"}, state, 0);
    chk({tag, " reset ir"}, ir, 0);
    @(negedge clk); reset = 1'b0; run = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t tbl[13];
    int   viol;

    tbl[0]  = mk_vec(32'hAB030041, 0, 0, 0, 0, mk_exp(4, 0, 0, 1, 0, 0, 1, 0, 6'b100010, 0));
    tbl[1]  = mk_vec(32'hEB030041, 0, 0, 0, 0, mk_exp(4, 0, 0, 1, 0, 0, 1, 0, 6'b100011, 0));
    tbl[2]  = mk_vec(32'h91000421, 0, 0, 0, 0, mk_exp(4, 0, 0, 1, 0, 0, 0, 0, 6'b010010, 0));
    tbl[3]  = mk_vec(32'hF8400000, 0, 0, 0, 2, mk_exp(7, 0, 0, 1, 4, 0, 0, 1, 6'b011010, 1));
    tbl[4]  = mk_vec(32'hF8000000, 0, 0, 0, 1, mk_exp(5, 0, 0, 0, 0, 2, 0, 0, 6'b011010, 1));
    tbl[5]  = mk_vec(32'hF8400000, 0, 0, 0, 0, mk_exp(5, 0, 0, 1, 2, 0, 0, 1, 6'b011010, 1));
    tbl[6]  = mk_vec(32'hB4000040, 1, 0, 0, 0, mk_exp(3, 1, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
    tbl[7]  = mk_vec(32'hB4000040, 0, 0, 0, 0, mk_exp(3, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
    tbl[8]  = mk_vec(32'h5400004B, 0, 1, 0, 0, mk_exp(3, 1, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
    tbl[9]  = mk_vec(32'h5400004B, 0, 1, 1, 0, mk_exp(3, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
    tbl[10] = mk_vec(32'h5400004B, 1, 0, 1, 0, mk_exp(3, 1, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
    tbl[11] = mk_vec(32'h14000003, 0, 0, 0, 0, mk_exp(3, 1, 1, 0, 0, 0, 0, 0, 6'b000000, 0));
    tbl[12] = mk_vec(32'hF8000000, 0, 0, 0, 0, mk_exp(4, 0, 0, 0, 0, 1, 0, 0, 6'b011010, 1));

    // Reset state, with run high to prove the fetch enable is held off.
    reset = 1'b1; run = 1'b1; instr_in = 32'hDEADBEEF;
    zero = 1'b0; flag_n = 1'b0; flag_v = 1'b0; mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("reset state", state, 0);
    chk("reset ir", ir, 0);
    chk("reset err", err, 0);
    chk("reset controls", ctrl, 0);
    @(negedge clk); reset = 1'b0; run = 1'b0;

    // Idle in FETCH while run is low.
    viol = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); instr_in = $urandom; #1;
      if (state !== 3'd0 || ctrl !== 15'd0 || ir !== 32'd0) viol++;
    end
    chk("idle fetch violations", viol, 0);

    // Directed vector table.
    for (int i = 0; i < 13; i++)
      run_instr($sformatf("vec%0d", i), tbl[i].instr, tbl[i].z, tbl[i].n,
                tbl[i].v, tbl[i].w, tbl[i].e);

    // Illegal opcodes: all-ones, and B.LT with a non-LT condition.
    err_seq("illegal ffffffff", 32'hFFFFFFFF, 12);
    err_seq("illegal b.cond", 32'h5400004A, 3);

    // Reset in the middle of a STUR memory wait.
    @(negedge clk); run = 1'b1; instr_in = 32'hF8000000; mem_ready = 1'b0; #1;
    @(negedge clk); run = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("stur mid-mem state", state, 3);
    chk("stur mid-mem mem_write", mem_write, 1);
    #1 reset = 1'b1; run = 1'b1; #1;
    chk("stur reset mem_write", mem_write, 0);
    chk("stur reset state", state, 0);
    chk("stur reset controls", ctrl, 0);
    @(negedge clk); reset = 1'b0; run = 1'b0;
    run_instr("stur refetch", 32'hF8000000, 0, 0, 0, 0,
              mk_exp(4, 0, 0, 0, 0, 1, 0, 0, 6'b011010, 1));

    // Random legal instructions against the instruction-level model.
    for (int k = 0; k < 60; k++) begin
      int c, w;
      bit z, n, v;
      logic [31:0] ins;
      c = $urandom_range(7, 0);
      w = $urandom_range(3, 0);
      z = 1'($urandom); n = 1'($urandom); v = 1'($urandom);
      ins = mk_instr(c);
      run_instr($sformatf("rand%0d class%0d %h", k, c, ins), ins, z, n, v, w,
                model(c, z, n, v, w));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; port names `clk` and `reset`.
REQ-002 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- run  in  1  permits leaving FETCH
- instr_in  in  32  instruction memory read data
- zero  in  1  live ALU zero flag
- flag_n, flag_v  in  1 each  stored negative/overflow flags
- mem_ready  in  1  data memory access complete
- ir  out  32  latched instruction
- state  out  3  current state encoding
- ir_en, pc_en, br_taken, uncond_br  out  1 each  fetch/PC control
- reg2loc, alu_src, imm_sel  out  1 each  operand select (imm_sel 0=Imm12, 1=DAddr9)
- alu_op  out  3  000 pass B, 010 add, 011 sub
- flag_en, mem_read, mem_write, mem_to_reg, reg_write  out  1 each  datapath enables
- err  out  1  illegal-opcode halt

Function
REQ-003 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7.
REQ-004 FETCH: stay while run=0; when run=1, assert ir_en, latch instr_in into ir, go to DECODE.
REQ-005 DECODE: classify ir and go to EXEC, or to ERR on any unlisted opcode. Opcodes:
- ADDI ir[31:22]=1001000100
- ADDS ir[31:21]=10101011000
- SUBS ir[31:21]=11101011000
- LDUR ir[31:21]=11111000010
- STUR ir[31:21]=11111000000
- B ir[31:26]=000101
- CBZ ir[31:24]=10110100
- B.LT ir[31:24]=01010100 with ir[4:0]=01011
REQ-006 EXEC outputs:
- ADDI: alu_src=1, imm_sel=0, alu_op=010.
- ADDS/SUBS: reg2loc=1, alu_op=010/011, flag_en=1.
- LDUR/STUR: alu_src=1, imm_sel=1, alu_op=010.
- CBZ: reg2loc=0, alu_op=000.
REQ-007 EXEC next state: ADDI/ADDS/SUBS -> WB; LDUR/STUR -> MEM; B/CBZ/B.LT -> FETCH.
REQ-008 B/CBZ/B.LT in EXEC SHALL assert pc_en.
- br_taken=1 for B, for CBZ when zero=1, and for B.LT when flag_n!=flag_v.
- uncond_br=1 only for B.
REQ-009 MEM: hold the address controls from EXEC.
- LDUR asserts mem_read; STUR asserts mem_write.
- Stay in MEM while mem_ready=0.
- On mem_ready=1: LDUR -> WB; STUR -> FETCH with pc_en=1, br_taken=0.
REQ-010 WB: assert reg_write and pc_en with br_taken=0.
- LDUR also asserts mem_to_reg and holds mem_read=1.
- Next state is FETCH.
REQ-011 pc_en SHALL be asserted exactly once per retired instruction, in its final cycle; PC is stable during all other cycles.
REQ-012 Instruction latency in cycles: ADD-class 4; LDUR 5+w; STUR 4+w; branches 3; w = mem_ready wait cycles.
REQ-013 Outputs SHALL be Moore/Mealy combinational from state, ir, zero, flags and mem_ready. Any output not specified for a state SHALL be 0.
REQ-014 mem_write and reg_write SHALL never be high in the same cycle; flag_en SHALL be high only in EXEC.
REQ-015 ERR: assert err=1, all other controls 0, remain until reset. run and mem_ready SHALL be ignored in ERR.
REQ-016 ir SHALL change only on an ir_en cycle.

Reset
REQ-017 reset=1 SHALL immediately force state=FETCH, ir=0, err=0 and all control outputs 0, including mid-MEM (mem_write drops asynchronously).
REQ-018 After reset deasserts, the first edge with run=1 SHALL perform the fetch.

Verification
REQ-019 ADDS X1,X2,X3 (0xAB030041), run=1 -> states 0,1,2,4,0. EXEC: reg2loc=1, alu_op=011 not asserted (010), flag_en=1. WB: reg_write=1, pc_en=1.
REQ-020 LDUR (0xF8400000) with mem_ready low 2 cycles -> MEM held 3 cycles with mem_read=1. WB: mem_to_reg=1, reg_write=1. Total 7 cycles.
REQ-021 CBZ (0xB4000040): zero=1 -> EXEC pc_en=1, br_taken=1. Repeat with zero=0 -> br_taken=0. Both return to FETCH after 3 cycles.
REQ-022 B.LT (0x5400004B): flag_n=1, flag_v=0 -> br_taken=1, uncond_br=0. Then flag_n=flag_v=1 -> br_taken=0.
REQ-023 instr_in=0xFFFFFFFF -> DECODE -> ERR, err=1 for 10+ cycles with run toggling. reset -> err=0, state=0.
REQ-024 Reset asserted mid-MEM of STUR -> mem_write falls before the next clock edge, state=0. Next run=1 re-fetches the instruction.
